alu_multicycle: RTL

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_muldiv_iter.sv | 74 +++++++
 rtl/alu_multicycle.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: sel codes, FSM state type, iterative op select.
// States MUL/DIV exist only when ALU_MULDIV_EN is defined.
package alu_pkg;

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_MUL = 4'b0011;
  localparam logic [3:0] SEL_DIV = 4'b0100;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SLT = 4'b0111;
  localparam logic [3:0] SEL_NOP = 4'b1000;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd1,
    ST_MUL  = 2'd2,
    ST_DIV  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd1
  } state_e;
`endif

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle for WIDTH cycles.
// Compiled only when ALU_MULDIV_EN is defined.
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done_c,
  output logic [WIDTH-1:0] result_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // x: multiplicand / divisor, y: multiplier / dividend-then-quotient, acc: product / remainder
  logic [CNT_W-1:0] cnt_q;
  logic             op_q;
  logic [WIDTH-1:0] x_q, y_q, acc_q;
  logic [WIDTH-1:0] x_d, y_d, acc_d;
  logic [WIDTH:0]   rem_sh_c, diff_c;

  // One iteration step for the selected operation
  always_comb begin
    rem_sh_c = {acc_q, y_q[WIDTH-1]};
    diff_c   = rem_sh_c - {1'b0, x_q};
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    if (op_q == OP_DIV) begin
      acc_d = diff_c[WIDTH] ? rem_sh_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
      y_d   = WIDTH'({y_q, ~diff_c[WIDTH]});
    end else begin
      acc_d = acc_q + (y_q[0] ? x_q : '0);
      x_d   = x_q << 1;
      y_d   = y_q >> 1;
    end
  end

  assign done_c   = busy && (cnt_q == CNT_W'(WIDTH - 1));
  assign result_c = (op_q == OP_DIV) ? y_d : acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt_q <= '0;
      op_q  <= OP_MUL;
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt_q <= '0;
      op_q  <= op;
      x_q   <= (op == OP_DIV) ? b : a;
      y_q   <= (op == OP_DIV) ? a : b;
      acc_q <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q + CNT_W'(1);
      x_q   <= x_d;
      y_q   <= y_d;
      acc_q <= acc_d;
      if (done_c) busy <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/arith ops plus optional iterative MUL/DIV.
// Define ALU_MULDIV_EN to compile in the iterative multiply/divide datapath.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] single_c, result_d;
  logic             zero_d, busy_d, done_d, dbz_d, div0_c;

`ifdef ALU_MULDIV_EN
  logic             iter_start_c, iter_op_c, iter_busy, iter_done_c;
  logic [WIDTH-1:0] iter_result_c;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (iter_start_c),
    .op       (iter_op_c),
    .a        (a),
    .b        (b),
    .busy     (iter_busy),
    .done_c   (iter_done_c),
    .result_c (iter_result_c)
  );

  assign div0_c = (sel == SEL_DIV) && (b == '0);
`else
  assign div0_c = 1'b0;
`endif

  // Single-cycle results; MUL/DIV reach here only when they finish in one cycle
  always_comb begin
    single_c = a + b;
    case (sel)
      SEL_AND: single_c = a & b;
      SEL_OR:  single_c = a | b;
      SEL_ADD: single_c = a + b;
      SEL_SUB: single_c = a - b;
      SEL_SLT: single_c = WIDTH'($signed(a) < $signed(b));
      SEL_MUL: single_c = '0;
      SEL_DIV: single_c = div0_c ? '1 : '0;
      SEL_NOP: single_c = '0;
      default: single_c = a + b;
    endcase
  end

  // Next-state and registered-output next values
  always_comb begin
    state_d  = state_q;
    result_d = result;
    dbz_d    = div_by_zero;
    done_d   = 1'b0;
`ifdef ALU_MULDIV_EN
    iter_start_c = 1'b0;
    iter_op_c    = OP_MUL;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d  = ST_DONE;
          result_d = single_c;
          dbz_d    = div0_c;
          done_d   = 1'b1;
`ifdef ALU_MULDIV_EN
          if (sel == SEL_MUL || (sel == SEL_DIV && !div0_c)) begin
            iter_start_c = 1'b1;
            iter_op_c    = (sel == SEL_DIV) ? OP_DIV : OP_MUL;
            state_d      = (sel == SEL_DIV) ? ST_DIV : ST_MUL;
            result_d     = result;
            dbz_d        = div_by_zero;
            done_d       = 1'b0;
          end
`endif
        end
      end
`ifdef ALU_MULDIV_EN
      ST_MUL, ST_DIV: begin
        if (iter_done_c) begin
          state_d  = ST_DONE;
          result_d = iter_result_c;
          dbz_d    = 1'b0;
          done_d   = 1'b1;
        end else if (!iter_busy) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    zero_d = (result_d == '0);
`ifdef ALU_MULDIV_EN
    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV);
`else
    busy_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      zero        <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      result      <= result_d;
      zero        <= zero_d;
      busy        <= busy_d;
      done        <= done_d;
      div_by_zero <= dbz_d;
    end
  end

endmodule
